// File: rtl/speed_meter.sv
// speed_meter: counts rising edges of async I_pulse per GATE_CYCLES window; `SPEED_GLITCH_FILTER_EN adds a FILTER_CYCLES debounce.
// Latency: a clean rise is counted 3 clocks later (3+FILTER_CYCLES with filter); results appear one clock after window end.
// Backpressure: none; O_valid is a one-cycle strobe and results hold until the next window closes.
module speed_meter #(
    parameter int GATE_CYCLES   = 100000,
    parameter int CNT_W         = 16,
    parameter int STOP_WINDOWS  = 4,
    parameter int FILTER_CYCLES = 8
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_pulse,
    input  logic             I_clr,
    output logic [CNT_W-1:0] O_speed,
    output logic             O_valid,
    output logic             O_sat,
    output logic             O_stopped
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int ZW = $clog2(STOP_WINDOWS + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [ZW-1:0] STOP_FULL = ZW'(STOP_WINDOWS);

    logic             sync_q1;
    logic             sync_q2;
    logic             lvl;
    logic             lvl_q;
    logic             pulse_edge;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_max;
    logic             sat_int;
    logic             sat_nxt;
    logic             win_end;
    logic [ZW-1:0]    zero_cnt;
    logic [ZW-1:0]    zero_nxt;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= I_pulse;
            sync_q2 <= sync_q1;
        end
    end

`ifdef SPEED_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_CYCLES - 1);

    logic           filt_lvl;
    logic [FCW-1:0] filt_cnt;

    // Level flips only after FILTER_CYCLES consecutive disagreeing samples; any bounce restarts the run.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            filt_lvl <= 1'b0;
            filt_cnt <= '0;
        end else if (sync_q2 == filt_lvl) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            filt_lvl <= sync_q2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = sync_q2;
`endif

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
        end
    end

    assign pulse_edge = lvl & ~lvl_q;
    assign win_end    = (gate_cnt == GATE_LAST);
    assign cnt_max    = &pulse_cnt;
    assign cnt_inc    = (pulse_edge && !cnt_max) ? pulse_cnt + 1'b1 : pulse_cnt;
    assign sat_nxt    = sat_int | (cnt_max & pulse_edge);

    // cnt_inc already folds in an edge landing on the closing cycle.
    always_comb begin
        zero_nxt = '0;
        if (cnt_inc == '0) begin
            zero_nxt = (zero_cnt == STOP_FULL) ? zero_cnt : zero_cnt + 1'b1;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            gate_cnt  <= '0;
            pulse_cnt <= '0;
            sat_int   <= 1'b0;
            zero_cnt  <= '0;
            O_speed   <= '0;
            O_valid   <= 1'b0;
            O_sat     <= 1'b0;
            O_stopped <= 1'b0;
        end else if (I_clr) begin
            gate_cnt  <= '0;
            pulse_cnt <= '0;
            sat_int   <= 1'b0;
            O_valid   <= 1'b0;
        end else if (win_end) begin
            gate_cnt  <= '0;
            pulse_cnt <= '0;
            sat_int   <= 1'b0;
            zero_cnt  <= zero_nxt;
            O_speed   <= cnt_inc;
            O_sat     <= sat_nxt;
            O_stopped <= (zero_nxt == STOP_FULL);
            O_valid   <= 1'b1;
        end else begin
            gate_cnt  <= gate_cnt + 1'b1;
            pulse_cnt <= cnt_inc;
            sat_int   <= sat_nxt;
            O_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_speed_meter.sv
`timescale 1ns/1ps
module tb_speed_meter;
    localparam int G    = 100;
    localparam int CW   = 4;
    localparam int SW   = 2;
    localparam int FC   = 8;
    localparam int MAXC = (1 << CW) - 1;
`ifdef SPEED_GLITCH_FILTER_EN
    localparam int LAT   = 3 + FC;
    localparam int MINW  = FC;
    localparam int MINLO = FC + 2;
`else
    localparam int LAT   = 3;
    localparam int MINW  = 1;
    localparam int MINLO = 2;
`endif

    logic          I_clk   = 1'b0;
    logic          I_rst_n = 1'b1;
    logic          I_pulse = 1'b0;
    logic          I_clr   = 1'b0;
    logic [CW-1:0] O_speed;
    logic          O_valid;
    logic          O_sat;
    logic          O_stopped;

    speed_meter #(
        .GATE_CYCLES  (G),
        .CNT_W        (CW),
        .STOP_WINDOWS (SW),
        .FILTER_CYCLES(FC)
    ) dut (
        .I_clk    (I_clk),
        .I_rst_n  (I_rst_n),
        .I_pulse  (I_pulse),
        .I_clr    (I_clr),
        .O_speed  (O_speed),
        .O_valid  (O_valid),
        .O_sat    (O_sat),
        .O_stopped(O_stopped)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        int e;
        int spd;
        bit sat;
        bit stp;
    } exp_t;

    exp_t q[$];
    int   ev[int];      // clock edge index -> number of edges the wheel produced there
    bit   clr_at[int];  // clock edge index at which I_clr is sampled
    int   edge_idx = 0;
    int   m_start  = 0;
    int   acc      = 0;
    int   zw       = 0;
    int   m_speed  = 0;
    bit   m_sat    = 1'b0;
    bit   m_stp    = 1'b0;
    bit   run      = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_idx, act, req);
        end
    endtask

    // Reference: windows are spans of GATE clock edges; an I_clr edge restarts the span and drops that edge's count.
    always @(posedge I_clk) begin
        if (run) begin
            edge_idx++;
            if (clr_at.exists(edge_idx)) begin
                acc     = 0;
                m_start = edge_idx;
            end else begin
                if (ev.exists(edge_idx)) acc += ev[edge_idx];
                if (edge_idx == m_start + G) begin
                    m_speed = (acc > MAXC) ? MAXC : acc;
                    m_sat   = (acc > MAXC);
                    if (m_speed == 0) zw = (zw < SW) ? zw + 1 : zw;
                    else              zw = 0;
                    m_stp   = (zw == SW);
                    q.push_back('{edge_idx, m_speed, m_sat, m_stp});
                    acc     = 0;
                    m_start = edge_idx;
                end
            end
        end
    end

    exp_t x;
    bit   exp_v;
    always @(negedge I_clk) begin
        if (run) begin
            exp_v = (q.size() > 0) && (q[0].e == edge_idx);
            if (O_valid || exp_v) chk("valid_strobe", O_valid, exp_v);
            if (exp_v) begin
                x = q.pop_front();
                if (O_valid) begin
                    chk("speed", O_speed, x.spd);
                    chk("sat", O_sat, x.sat);
                    chk("stopped", O_stopped, x.stp);
                end
            end
            chk("hold_speed", O_speed, m_speed);
            chk("hold_sat", O_sat, m_sat);
            chk("hold_stopped", O_stopped, m_stp);
        end
    end

    task automatic tick(input bit p, input bit c);
        I_pulse = p;
        I_clr   = c;
        if (c) clr_at[edge_idx + 1] = 1'b1;
        @(posedge I_clk);
        #1;
    endtask

    task automatic add_ev(input int e);
        if (ev.exists(e)) ev[e] = ev[e] + 1;
        else              ev[e] = 1;
    endtask

    task automatic pulse(input int hi, input int lo);
        if (hi >= MINW) add_ev(edge_idx + LAT);
        repeat (hi) tick(1'b1, 1'b0);
        repeat (lo) tick(1'b0, 1'b0);
    endtask

    task automatic train(input int n, input int hi, input int lo);
        repeat (n) pulse(hi, lo);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    // I_clr lands on the very edge where this pulse would have been counted.
    task automatic pulse_clr(input int lo);
        add_ev(edge_idx + LAT);
        repeat (LAT - 1) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (lo) tick(1'b0, 1'b0);
    endtask

    task automatic wait_to(input int off);
        int guard;
        guard = 0;
        while (edge_idx != m_start + off && guard < 3 * G) begin
            tick(1'b0, 1'b0);
            guard++;
        end
        if (guard >= 3 * G) begin
            checks++;
            errors++;
            $display("FAIL wait_to timeout: offset %0d not reached, got edge %0d", off, edge_idx);
        end
    endtask

    task automatic model_clear();
        q.delete();
        ev.delete();
        clr_at.delete();
        edge_idx = 0;
        m_start  = 0;
        acc      = 0;
        zw       = 0;
        m_speed  = 0;
        m_sat    = 1'b0;
        m_stp    = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_speed"}, O_speed, 0);
        chk({tag, "_valid"}, O_valid, 0);
        chk({tag, "_sat"}, O_sat, 0);
        chk({tag, "_stopped"}, O_stopped, 0);
    endtask

    task automatic release_rst();
        repeat (3) @(posedge I_clk);
        #1;
        I_rst_n = 1'b1;
        run     = 1'b1;
    endtask

    int n, hi, lo;
    initial begin
        #1 I_rst_n = 1'b0;
        #12;
        check_zero("reset");
        model_clear();
        release_rst();

`ifdef SPEED_GLITCH_FILTER_EN
        train(15, 10, 10);
        repeat (6) pulse(3, 15);
        idle(G);
        repeat (6) begin
            n  = $urandom_range(3, 10);
            hi = ($urandom_range(0, 1) == 1) ? 3 : $urandom_range(FC + 2, FC + 8);
            lo = $urandom_range(FC + 2, FC + 8);
            train(n, hi, lo);
            if ($urandom_range(0, 2) == 0) pulse_clr(MINLO);
        end
`else
        train(30, 5, 5);
        train(75, 2, 2);
        train(30, 5, 5);
        repeat (8) begin
            n  = $urandom_range(5, 30);
            hi = $urandom_range(2, 6);
            lo = $urandom_range(2, 8);
            train(n, hi, lo);
            case ($urandom_range(0, 3))
                0:       tick(1'b0, 1'b1);
                1:       pulse_clr(2);
                2:       idle($urandom_range(1, 150));
                default: ;
            endcase
        end
`endif

        // Edge coinciding with the closing cycle, then stall, then recovery.
        idle(MINLO);
        wait_to(G - LAT);
        pulse(MINLO, MINLO);
        idle(2 * G);
        wait_to(10);
        pulse(MINLO, MINLO);
        idle(G);

        // Mid-window clear holds outputs and restarts the window.
        train(10, MINLO + 3, MINLO + 3);
        wait_to(49);
        tick(1'b0, 1'b1);
        train(25, MINLO + 3, MINLO + 3);

        // Asynchronous reset mid-window.
        train(8, MINLO + 3, MINLO + 3);
        I_pulse = 1'b0;
        #3;
        I_rst_n = 1'b0;
        run     = 1'b0;
        #1;
        check_zero("midrst");
        model_clear();
        release_rst();
        train(25, MINLO + 3, MINLO + 3);
        idle(G + 10);

        chk("pending_windows", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
